// File: rtl/vga_layer_compositor.sv
// Registered two-stage VGA layer compositor: frame-latched object shadows, priority colour mux, per-obstacle collisions.
// Optional feature macro: VGA_COMP_SCANLINE_EN (halves output intensity on odd scanlines).
module vga_layer_compositor #(
   parameter int NUM_OBS         = 4,
   parameter int COORD_W         = 10,
   parameter int BOX_WIDTH       = 30,
   parameter int BOX_BASE_HEIGHT = 30,
   parameter int BOX_Y_START     = 315,
   parameter int BANK_X_START    = 50,
   parameter int BANK_WIDTH      = 60,
   parameter int FLASH_FRAMES    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_start,
   input  logic [COORD_W-1:0]           x,
   input  logic [COORD_W-1:0]           y,
   input  logic                         active_pixels,
   input  logic [1:0]                   game_state,
   input  logic                         menu_selection,
   input  logic [8:0]                   txt_flags,
   input  logic [COORD_W-1:0]           player_x,
   input  logic [COORD_W-1:0]           player_height,
   input  logic [COORD_W-1:0]           green_x,
   input  logic [COORD_W-1:0]           green_y,
   input  logic [COORD_W-1:0]           green_w,
   input  logic [COORD_W-1:0]           green_h,
   input  logic                         green_active,
   input  logic [NUM_OBS*4*COORD_W-1:0] obs_rect,
   input  logic [NUM_OBS-1:0]           obs_active,
   input  logic                         hit_pulse,
   output logic [7:0]                   VGA_R,
   output logic [7:0]                   VGA_G,
   output logic [7:0]                   VGA_B,
   output logic [NUM_OBS-1:0]           coll_flags,
   output logic                         coll_valid
);

   localparam int CW = COORD_W;
   localparam int EW = COORD_W + 1;
   localparam logic [EW-1:0] Y_START  = EW'(BOX_Y_START);
   localparam logic [EW-1:0] HELD_LIM = EW'(BOX_Y_START - BOX_BASE_HEIGHT + 1);
   localparam logic [EW-1:0] BANK_X0  = EW'(BANK_X_START);
   localparam logic [EW-1:0] BANK_X1  = EW'(BANK_X_START + BANK_WIDTH);

   localparam logic [23:0] C_RED   = 24'hFF0000;
   localparam logic [23:0] C_GREEN = 24'h00FF00;
   localparam logic [23:0] C_BLUE  = 24'h0000FF;
   localparam logic [23:0] C_WHITE = 24'hFFFFFF;
   localparam logic [23:0] C_DIM   = 24'h555555;
   localparam logic [23:0] C_GRAY  = 24'h808080;
   localparam logic [23:0] C_NAVY  = 24'h000080;
   localparam logic [23:0] C_BLACK = 24'h000000;

   typedef enum logic [1:0] {
      ST_START   = 2'b00,
      ST_PLAYING = 2'b01,
      ST_INSTR   = 2'b10,
      ST_OVER    = 2'b11
   } state_t;

   // Edges are summed one bit wider than the coordinates so a rectangle near the limit never wraps.
   function automatic logic in_rect(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                    input logic [CW-1:0] rx, input logic [CW-1:0] ry,
                                    input logic [CW-1:0] rw, input logic [CW-1:0] rh);
      logic [EW-1:0] x_end;
      logic [EW-1:0] y_end;
      x_end = {1'b0, rx} + {1'b0, rw};
      y_end = {1'b0, ry} + {1'b0, rh};
      return (rw != '0) && (rh != '0) &&
             ({1'b0, px} >= {1'b0, rx}) && ({1'b0, px} < x_end) &&
             ({1'b0, py} >= {1'b0, ry}) && ({1'b0, py} < y_end);
   endfunction

   logic [NUM_OBS*4*CW-1:0] sh_obs_rect;
   logic [NUM_OBS-1:0]      sh_obs_active;
   logic [CW-1:0]           sh_player_x, sh_player_height;
   logic [CW-1:0]           sh_green_x, sh_green_y, sh_green_w, sh_green_h;
   logic                    sh_green_active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_obs_rect      <= '0;
         sh_obs_active    <= '0;
         sh_player_x      <= '0;
         sh_player_height <= '0;
         sh_green_x       <= '0;
         sh_green_y       <= '0;
         sh_green_w       <= '0;
         sh_green_h       <= '0;
         sh_green_active  <= 1'b0;
      end else if (frame_start) begin
         sh_obs_rect      <= obs_rect;
         sh_obs_active    <= obs_active;
         sh_player_x      <= player_x;
         sh_player_height <= player_height;
         sh_green_x       <= green_x;
         sh_green_y       <= green_y;
         sh_green_w       <= green_w;
         sh_green_h       <= green_h;
         sh_green_active  <= green_active;
      end
   end

   logic [NUM_OBS-1:0] obs_hit;
   logic [EW-1:0]      player_top;
   logic               player_hit, held_row, bank_hit, floor_row, green_hit;

   always_comb begin
      obs_hit = '0;
      for (int i = 0; i < NUM_OBS; i++) begin
         obs_hit[i] = sh_obs_active[i] &&
                      in_rect(x, y, sh_obs_rect[i*4*CW+3*CW +: CW], sh_obs_rect[i*4*CW+2*CW +: CW],
                              sh_obs_rect[i*4*CW+CW +: CW], sh_obs_rect[i*4*CW +: CW]);
      end
      player_top = ({1'b0, sh_player_height} > Y_START) ? '0 : Y_START - {1'b0, sh_player_height} + EW'(1);
      player_hit = ({1'b0, x} >= {1'b0, sh_player_x}) &&
                   ({1'b0, x} < {1'b0, sh_player_x} + EW'(BOX_WIDTH)) &&
                   ({1'b0, y} >= player_top) && ({1'b0, y} <= Y_START);
      held_row   = {1'b0, y} < HELD_LIM;
      bank_hit   = ({1'b0, x} >= BANK_X0) && ({1'b0, x} < BANK_X1) &&
                   ({1'b0, y} >= HELD_LIM) && ({1'b0, y} <= Y_START);
      floor_row  = {1'b0, y} > Y_START;
      green_hit  = sh_green_active && in_rect(x, y, sh_green_x, sh_green_y, sh_green_w, sh_green_h);
   end

   logic               s1_active, s1_odd;
   logic [8:0]         s1_flags;
   state_t             s1_state;
   logic [NUM_OBS-1:0] s1_obs;
   logic               s1_green, s1_player, s1_held, s1_bank, s1_floor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_active <= 1'b0;
         s1_odd    <= 1'b0;
         s1_flags  <= '0;
         s1_state  <= ST_START;
         s1_obs    <= '0;
         s1_green  <= 1'b0;
         s1_player <= 1'b0;
         s1_held   <= 1'b0;
         s1_bank   <= 1'b0;
         s1_floor  <= 1'b0;
      end else begin
         s1_active <= active_pixels;
         s1_odd    <= y[0];
         s1_flags  <= txt_flags;
         s1_state  <= state_t'(game_state);
         s1_obs    <= obs_hit;
         s1_green  <= green_hit;
         s1_player <= player_hit;
         s1_held   <= held_row;
         s1_bank   <= bank_hit;
         s1_floor  <= floor_row;
      end
   end

   // A hit_pulse landing on a frame_start reloads the full count rather than being decremented.
   logic [7:0] flash_cnt;
   logic       blink_off;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                flash_cnt <= '0;
      else if (hit_pulse)                     flash_cnt <= 8'(FLASH_FRAMES);
      else if (frame_start && flash_cnt != 0) flash_cnt <= flash_cnt - 8'd1;
   end

   assign blink_off = (flash_cnt != 0) && flash_cnt[0];

   logic [23:0] colour, colour_out;

   always_comb begin
      colour = C_BLACK;
      if (s1_active) begin
         case (s1_state)
            ST_START: begin
               if (s1_flags[3])      colour = menu_selection ? C_DIM : C_WHITE;
               else if (s1_flags[4]) colour = menu_selection ? C_WHITE : C_DIM;
               else                  colour = C_NAVY;
            end
            ST_INSTR: begin
               if (s1_flags[5])      colour = C_GREEN;
               else if (s1_flags[6]) colour = C_RED;
               else if (s1_flags[7]) colour = C_WHITE;
               else                  colour = C_BLACK;
            end
            ST_OVER:                 colour = s1_flags[8] ? C_WHITE : C_RED;
            ST_PLAYING: begin
               if (s1_flags[0])                    colour = C_RED;
               else if (s1_flags[1] | s1_flags[2]) colour = C_BLACK;
               else if (|s1_obs)                   colour = C_RED;
               else if (s1_green)                  colour = C_GREEN;
               else if (s1_player)                 colour = s1_held ? C_GREEN : (blink_off ? C_WHITE : C_BLUE);
               else if (s1_bank)                   colour = C_GREEN;
               else if (s1_floor)                  colour = C_GRAY;
               else                                colour = C_WHITE;
            end
         endcase
      end
`ifdef VGA_COMP_SCANLINE_EN
      colour_out = (s1_active && s1_odd) ?
                   {1'b0, colour[23:17], 1'b0, colour[15:9], 1'b0, colour[7:1]} : colour;
`else
      colour_out = colour;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) {VGA_R, VGA_G, VGA_B} <= '0;
      else     {VGA_R, VGA_G, VGA_B} <= colour_out;
   end

   // Hits seen while frame_start is high belong to the frame that is just opening.
   logic [NUM_OBS-1:0] coll_acc, coll_now;

   assign coll_now = (s1_state == ST_PLAYING && s1_active && s1_player) ? s1_obs : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coll_acc   <= '0;
         coll_flags <= '0;
         coll_valid <= 1'b0;
      end else begin
         coll_valid <= frame_start;
         if (frame_start) begin
            coll_flags <= coll_acc;
            coll_acc   <= coll_now;
         end else begin
            coll_acc   <= coll_acc | coll_now;
         end
      end
   end

endmodule
